// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter in front of a shared 8:1 single-bit select path.
//   A two-state FSM (IDLE/GRANT) picks one requester, starting the search at
//   a rotating priority pointer. It then forwards that source's data bit on
//   every cycle where the source keeps requesting. The grant ends when the
//   request drops or after MAX_HOLD transfers.
//
// Parameters
//   MAX_HOLD   : maximum consecutive transfer cycles per grant (1..255)
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous active-high reset
//   req[7:0]   : request per source
//   in[7:0]    : data bit per source
//   sel[2:0]   : registered index of the granted (or last granted) source
//   grant[7:0] : registered one-hot grant, zero when nothing is granted
//   busy       : high while in GRANT
//   data_out   : registered copy of in[sel] from the latest transfer cycle
//   data_valid : high for the cycle after each transfer cycle
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic [7:0] in,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic       busy,
  output logic       data_out,
  output logic       data_valid
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     state_reg;
  logic [2:0] ptr_reg;
  logic [7:0] hold_cnt_reg;

  // Requests rotated so that bit 0 is the source the pointer names.
  // The first set bit of rot_req is then the round-robin winner.
  logic [7:0] rot_req;

  for (genvar gi = 0; gi < 8; gi++) begin : g_rot
    assign rot_req[gi] = req[ptr_reg + 3'(gi)];
  end

  logic [2:0] win_off;
  logic       win_found;
  logic [2:0] winner;

  always_comb begin
    win_off   = 3'd0;
    win_found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!win_found && rot_req[i]) begin
        win_found = 1'b1;
        win_off   = 3'(i);
      end
    end
  end

  assign winner = ptr_reg + win_off;

  // The last allowed transfer of a grant is the one that brings the count
  // to MAX_HOLD.
  logic last_transfer;
  assign last_transfer = (hold_cnt_reg + 8'd1) == 8'(MAX_HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= 3'd0;
      hold_cnt_reg <= 8'd0;
      sel          <= 3'd0;
      grant        <= 8'd0;
      busy         <= 1'b0;
      data_out     <= 1'b0;
      data_valid   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (win_found) begin
            state_reg    <= ST_GRANT;
            busy         <= 1'b1;
            sel          <= winner;
            grant        <= 8'd1 << winner;
            hold_cnt_reg <= 8'd0;
          end
        end
        ST_GRANT: begin
          if (req[sel]) begin
            // Transfer cycle.
            data_out     <= in[sel];
            data_valid   <= 1'b1;
            hold_cnt_reg <= hold_cnt_reg + 8'd1;
            if (last_transfer) begin
              state_reg <= ST_IDLE;
              busy      <= 1'b0;
              grant     <= 8'd0;
              ptr_reg   <= sel + 3'd1;
            end
          end else begin
            // The granted source dropped its request: release with no transfer.
            // sel is left alone so it still names the last granted source.
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
            grant     <= 8'd0;
            ptr_reg   <= sel + 3'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
          grant     <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 4, maximum consecutive transfer cycles per grant; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  8  request per source; req[i] high means source i wants the shared 8:1 select path.
REQ-005 Port: in  input  8  data bit per source; in[i] belongs to source i.
REQ-006 Port: sel  output  3  select index of the granted source, registered.
REQ-007 Port: grant  output  8  one-hot grant, registered; all-zero when no source is granted.
REQ-008 Port: busy  output  1  high while in GRANT state.
REQ-009 Port: data_out  output  1  registered copy of in[sel] captured on a transfer cycle.
REQ-010 Port: data_valid  output  1  high for exactly the cycle after each transfer cycle.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-012 The block SHALL keep a 3-bit priority pointer ptr; the search order is ptr, ptr+1, ..., ptr+7, modulo 8 (7 wraps to 0).
REQ-013 In IDLE with req != 0, the block SHALL pick the first requester in search order, then on the next edge: state = GRANT, sel = winner, grant = one-hot(winner), hold_cnt = 0.
REQ-014 In IDLE with req == 0, the block SHALL stay in IDLE and hold sel, with grant = 0.
REQ-015 A transfer cycle SHALL be any GRANT cycle with req[sel] = 1. On it: data_out <= in[sel], data_valid <= 1, hold_cnt <= hold_cnt + 1.
REQ-016 In every other cycle, data_valid SHALL be 0 and data_out SHALL hold its value.
REQ-017 Release SHALL occur in either of two cases: (a) in GRANT with req[sel] = 0, with no transfer; or (b) on a transfer cycle where hold_cnt + 1 == MAX_HOLD.
REQ-018 On release, on the same edge: state = IDLE, grant = 0, ptr = sel + 1 mod 8; sel SHALL hold.
REQ-019 Latency: a request seen in IDLE at edge t SHALL give grant at t+1; the first data_valid SHALL appear at t+2 at the earliest.
REQ-020 After every release there SHALL be exactly one IDLE cycle before the next grant, even when req stays non-zero.
REQ-021 Requests from sources other than sel SHALL be ignored during GRANT; a request dropped before arbitration is not remembered.
REQ-022 A sole requester held past MAX_HOLD SHALL be re-granted after the one IDLE cycle; ptr wrap still applies.
REQ-023 hold_cnt SHALL be 8 bits wide and never exceed MAX_HOLD; grant SHALL never have more than one bit set.
REQ-024 Changes of in[] outside transfer cycles SHALL have no effect on data_out.

Reset
REQ-025 While reset = 1 at a rising edge, the block SHALL set state = IDLE, ptr = 0, hold_cnt = 0, sel = 0, grant = 0, busy = 0, data_out = 0, data_valid = 0.
REQ-026 Reset SHALL take priority over all other behaviour, including release and transfer, and SHALL abort a grant in progress.
REQ-027 After reset deasserts, the first arbitration SHALL start from ptr = 0.

Verification
REQ-028 Reset, then req = 8'b0000_0001 held, in[0] = 1, MAX_HOLD = 4: grant = 01 one cycle after; 4 data_valid pulses with data_out = 1; then 1 IDLE cycle; then regrant.
REQ-029 req = 8'hFF constant after reset, MAX_HOLD = 1: sel sequence 0,1,2,...,7,0 with one IDLE cycle between each grant; the wrap from 7 to 0 is checked.
REQ-030 Source 3 granted; drop req[3] after 2 transfers: release on the next cycle; ptr = 4; no data_valid during the release cycle.
REQ-031 ptr = 6, req = 8'b0100_0001: source 6 wins; after release ptr = 7, and source 0 wins next.
REQ-032 Assert reset mid-GRANT at sel = 5: on the next cycle all outputs are 0 and state = IDLE; with req = 8'b0010_0001 afterwards, source 0 wins.
REQ-033 Toggle in[] on non-transfer cycles: data_out is unchanged and data_valid stays 0.
